// File: rtl/timebase_gen.sv
`default_nettype none
// ============================================================================
//  Module      : timebase_gen
//  Description : Programmable usec / msec / sec timebase generator.
//                A prescaler divides clk by divFactor (0 treated as 1) to form
//                usec intervals; two TICKS-modulo counters derive msec and sec
//                intervals. Each unit has a one-cycle pulse at the end of its
//                interval and a square wave that is high in the first half.
//  Ports       : clk        - sole clock, rising edge
//                rst_n      - asynchronous active-low reset
//                en         - count enable (pulses forced low while 0)
//                sync_clr   - synchronous restart, overrides en
//                divFactor  - clk cycles per usec interval
//                usec_pulse, msec_pulse, sec_pulse - single-cycle ticks
//                usec_clk,   msec_clk,   sec_clk   - unit-period square waves
//  Revision    : 1.0 - initial release
// ============================================================================
module timebase_gen #(
    parameter int DIV_W = 10,
    parameter int TICKS = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync_clr,
    input  logic [DIV_W-1:0] divFactor,
    output logic             usec_pulse,
    output logic             msec_pulse,
    output logic             sec_pulse,
    output logic             usec_clk,
    output logic             msec_clk,
    output logic             sec_clk
);

    localparam logic [9:0] c_TOP  = 10'(TICKS - 1);
    localparam logic [9:0] c_HALF = 10'(TICKS / 2);

    // r_pre is the position inside the current usec interval; 0 means the
    // next enabled edge starts a new interval and re-samples the period.
    logic [DIV_W-1:0] r_pre;
    logic [DIV_W-1:0] r_per;
    logic [9:0]       r_ucnt;
    logic [9:0]       r_mcnt;

    logic r_usec_pulse;
    logic r_msec_pulse;
    logic r_sec_pulse;
    logic r_usec_clk;
    logic r_msec_clk;
    logic r_sec_clk;

    logic [DIV_W-1:0] w_per;
    logic [DIV_W-1:0] w_pos;
    logic             w_pulse;
    logic             w_msec;
    logic             w_sec;
    logic             w_uclk;

    always_comb begin
        w_per = r_per;
        if (r_pre == '0) begin
            w_per = (divFactor == '0) ? DIV_W'(1) : divFactor;
        end
        // r_pre < period, so the increment never exceeds the period width.
        w_pos   = r_pre + DIV_W'(1);
        w_pulse = (w_pos == w_per);
        w_msec  = w_pulse && (r_ucnt == c_TOP);
        w_sec   = w_msec && (r_mcnt == c_TOP);
        // The pulse cycle is position 0 (mod P); a period of 1 never goes high.
        w_uclk  = !w_pulse && (w_pos <= (w_per >> 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre        <= '0;
            r_per        <= '0;
            r_ucnt       <= '0;
            r_mcnt       <= '0;
            r_usec_pulse <= 1'b0;
            r_msec_pulse <= 1'b0;
            r_sec_pulse  <= 1'b0;
            r_usec_clk   <= 1'b0;
            r_msec_clk   <= 1'b0;
            r_sec_clk    <= 1'b0;
        end else if (sync_clr) begin
            r_pre        <= '0;
            r_per        <= '0;
            r_ucnt       <= '0;
            r_mcnt       <= '0;
            r_usec_pulse <= 1'b0;
            r_msec_pulse <= 1'b0;
            r_sec_pulse  <= 1'b0;
            r_usec_clk   <= 1'b0;
            r_msec_clk   <= 1'b0;
            r_sec_clk    <= 1'b0;
        end else if (en) begin
            r_per        <= w_per;
            r_pre        <= w_pulse ? '0 : w_pos;
            r_usec_pulse <= w_pulse;
            r_msec_pulse <= w_msec;
            r_sec_pulse  <= w_sec;
            r_usec_clk   <= w_uclk;
            // The counters still hold the index of the interval that the
            // new cycle belongs to; they advance on the pulse of its last cycle.
            r_msec_clk   <= (r_ucnt < c_HALF);
            r_sec_clk    <= (r_mcnt < c_HALF);
            if (w_pulse) begin
                r_ucnt <= (r_ucnt == c_TOP) ? 10'd0 : r_ucnt + 10'd1;
            end
            if (w_msec) begin
                r_mcnt <= (r_mcnt == c_TOP) ? 10'd0 : r_mcnt + 10'd1;
            end
        end else begin
            r_usec_pulse <= 1'b0;
            r_msec_pulse <= 1'b0;
            r_sec_pulse  <= 1'b0;
        end
    end

    assign usec_pulse = r_usec_pulse;
    assign msec_pulse = r_msec_pulse;
    assign sec_pulse  = r_sec_pulse;
    assign usec_clk   = r_usec_clk;
    assign msec_clk   = r_msec_clk;
    assign sec_clk    = r_sec_clk;

endmodule
`default_nettype wire

// File: doc/timebase_gen.md
TIMEBASE_GEN -- requirements
Module: timebase_gen

Interface
REQ-001 SHALL have parameter DIV_W, default 10: width of divFactor.
REQ-002 SHALL have parameter TICKS, default 1000, legal range 2..1023 and even: usec per msec and msec per sec.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port en, input, 1: count enable.
REQ-006 SHALL have port sync_clr, input, 1: synchronous restart of all counters.
REQ-007 SHALL have port divFactor, input, DIV_W: clk cycles per usec interval.
REQ-008 SHALL have ports usec_pulse, msec_pulse and sec_pulse, output, 1 each: single-cycle tick per unit interval.
REQ-009 SHALL have ports usec_clk, msec_clk and sec_clk, output, 1 each: square wave with period of one unit.
REQ-010 SHALL drive every output directly from a flop.

Function
REQ-011 SHALL compute the period P = divFactor, treating divFactor==0 as P=1.
REQ-012 SHALL count an enabled cycle index c, where c=1 is the first cycle after the first rising edge with en=1 following a reset or clear.
REQ-013 SHALL assert usec_pulse iff c mod P == 0 (c>=1), and keep it high for exactly one cycle.
REQ-014 SHALL maintain a usec counter in the range 0..TICKS-1 that increments on each usec_pulse and wraps to 0.
REQ-015 SHALL assert msec_pulse in the same cycle as the usec_pulse that wraps the usec counter (c mod P*TICKS == 0).
REQ-016 SHALL maintain a msec counter in the range 0..TICKS-1 that advances on msec_pulse.
REQ-017 SHALL assert sec_pulse coincident with the msec_pulse that wraps the msec counter; all three pulses SHALL be edge-aligned when they coincide.
REQ-018 SHALL drive usec_clk high iff (c mod P) is in 1..floor(P/2); for P=1, usec_clk SHALL stay 0.
REQ-019 SHALL define usec interval i as spanning cycles i*P+1 .. (i+1)*P.
REQ-020 SHALL drive msec_clk high during usec intervals whose usec-counter value is in 0..TICKS/2-1.
REQ-021 SHALL drive sec_clk high during msec intervals whose msec-counter value is in 0..TICKS/2-1.
REQ-022 SHALL fix each usec interval's length with the divFactor value sampled at that interval's first cycle; a mid-interval change SHALL take effect from the next interval only.
REQ-023 SHALL, when en=0, hold all counters and *_clk outputs and force all *_pulse outputs to 0; counting SHALL resume from the held state when en returns to 1.
REQ-024 SHALL, when sync_clr=1 at an edge, return all counters and outputs to their reset values, with priority over en.
REQ-025 SHALL size the prescaler at DIV_W bits and the usec and msec counters at 10 bits, with no overflow for any legal divFactor or TICKS.

Reset
REQ-026 SHALL, while rst_n=0, immediately force all outputs to 0, all counters to 0, and the sampled period to be re-taken at the first enabled cycle.
REQ-027 SHALL, on rst_n assertion mid-interval, discard the partial interval; the first usec_pulse after release SHALL occur P enabled cycles later.

Verification (TICKS=4)
REQ-028 SHALL verify: divFactor=3, en=1 after reset -> usec_pulse at c=3,6,9..., msec_pulse at c=12,24, sec_pulse at c=48, all pulses high at c=48.
REQ-029 SHALL verify: divFactor=4 -> usec_clk high at c=1,2 and low at c=3,4 in every interval; msec_clk high for c=1..8 and low for c=9..16.
REQ-030 SHALL verify: divFactor=0 and divFactor=1 -> usec_pulse high every cycle, usec_clk constant 0, msec_pulse every 4 cycles.
REQ-031 SHALL verify: divFactor changed 3->5 at c=4 -> next usec_pulse at c=6, then c=11.
REQ-032 SHALL verify: en=0 for 7 cycles starting at c=5 with divFactor=3 -> no pulses during the gap, next usec_pulse 1 enabled cycle after resume.
REQ-033 SHALL verify: rst_n or sync_clr asserted at c=10 -> outputs 0 on the next edge (rst_n immediately), and the first usec_pulse P cycles after release; sync_clr=1 together with en=0 -> clear still takes effect.
